// File: rtl/bp_seq_pkg.sv
// Shared types for the branch-predictor access sequencer.
package bp_seq_pkg;

    localparam int BP_PC_W = 10;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        UPDATE
    } state_t;

    typedef struct packed {
        logic [BP_PC_W-1:0] pc;
        logic               pred;
    } bp_entry_t;

endpackage

// File: rtl/bp_inflight_fifo.sv
// In-order queue of in-flight branches: circular buffer with wrapping pointers and a count.
module bp_inflight_fifo
    import bp_seq_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = bp_entry_t
) (
    input  logic                   i_clock,
    input  logic                   i_reset_n,
    input  logic                   i_push,
    input  entry_t                 i_push_data,
    input  logic                   i_pop,
    output entry_t                 o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);

    entry_t           r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Storage is not reset; the count alone defines which slots are live.
    always_ff @(posedge i_clock) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/bp_access_sequencer.sv
// Shares the predictor's single PC/BranchTaken port between fetch lookups and resolutions.
// Optional statistics outputs are enabled with BP_SEQ_STATS_EN.
module bp_access_sequencer
    import bp_seq_pkg::*;
#(
    parameter int PC_W       = BP_PC_W,
    parameter int DEPTH      = 4,
    parameter int LOOKUP_CYC = 4,
    parameter int UPDATE_CYC = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   lk_valid,
    input  logic [PC_W-1:0]        lk_pc,
    output logic                   lk_ready,
    output logic                   pred_valid,
    output logic                   pred_taken,
    input  logic                   rs_valid,
    input  logic                   rs_taken,
    output logic                   rs_ready,
    output logic                   mispredict,
    output logic [PC_W-1:0]        bp_pc,
    output logic                   bp_taken,
    input  logic                   bp_predicted,
    output logic [$clog2(DEPTH):0] q_count
`ifdef BP_SEQ_STATS_EN
    ,
    output logic [15:0]            stat_lookups,
    output logic [15:0]            stat_mispredicts,
    output logic                   stat_orphan
`endif
);

    localparam int MAX_CYC = (LOOKUP_CYC > UPDATE_CYC) ? LOOKUP_CYC : UPDATE_CYC;
    localparam int PH_W    = $clog2(MAX_CYC) + 1;
    localparam logic [PH_W-1:0] LK_LAST = PH_W'(LOOKUP_CYC - 1);
    localparam logic [PH_W-1:0] UP_LAST = PH_W'(UPDATE_CYC - 1);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            pred;
    } entry_t;

    state_t          r_state;
    logic [PH_W-1:0] r_phase;
    logic [PC_W-1:0] r_pc;
    logic            r_taken;
    logic            r_pred_valid;
    logic            r_pred_taken;

    entry_t          w_head;
    entry_t          w_push_data;
    logic            w_full;
    logic            w_empty;
    logic            w_rs_go;
    logic            w_lk_go;
    logic            w_lk_last;

    // Resolution has strict priority: it frees queue slots a blocked lookup may need.
    assign w_rs_go     = (r_state == IDLE) && rs_valid && !w_empty;
    assign w_lk_go     = (r_state == IDLE) && !w_rs_go && lk_valid && !w_full;
    assign w_lk_last   = (r_state == LOOKUP) && (r_phase == LK_LAST);
    assign w_push_data = '{pc: r_pc, pred: bp_predicted};

    assign rs_ready    = w_rs_go;
    assign lk_ready    = w_lk_go;
    assign mispredict  = w_rs_go && (rs_taken != w_head.pred);
    assign pred_valid  = r_pred_valid;
    assign pred_taken  = r_pred_taken;
    assign bp_pc       = (r_state == IDLE) ? '0 : r_pc;
    assign bp_taken    = (r_state == UPDATE) && r_taken;

    bp_inflight_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .i_clock     (clock),
        .i_reset_n   (reset),
        .i_push      (w_lk_last),
        .i_push_data (w_push_data),
        .i_pop       (w_rs_go),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (q_count)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_phase      <= '0;
            r_pc         <= '0;
            r_taken      <= 1'b0;
            r_pred_valid <= 1'b0;
            r_pred_taken <= 1'b0;
        end else begin
            r_pred_valid <= 1'b0;
            r_pred_taken <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_phase <= '0;
                    if (w_rs_go) begin
                        r_pc    <= w_head.pc;
                        r_taken <= rs_taken;
                        r_state <= UPDATE;
                    end else if (w_lk_go) begin
                        r_pc    <= lk_pc;
                        r_taken <= 1'b0;
                        r_state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (r_phase == LK_LAST) begin
                        r_pred_valid <= 1'b1;
                        r_pred_taken <= bp_predicted;
                        r_state      <= IDLE;
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
                UPDATE: begin
                    if (r_phase == UP_LAST) begin
                        r_taken <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef BP_SEQ_STATS_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stat_lookups     <= '0;
            stat_mispredicts <= '0;
            stat_orphan      <= 1'b0;
        end else begin
            if (w_lk_go && (stat_lookups != 16'hFFFF))
                stat_lookups <= stat_lookups + 1'b1;
            if (mispredict && (stat_mispredicts != 16'hFFFF))
                stat_mispredicts <= stat_mispredicts + 1'b1;
            if ((r_state == IDLE) && rs_valid && w_empty)
                stat_orphan <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/bp_access_sequencer.md
Name: bp_access_sequencer

Overview:
- Owns the single PC/BranchTaken port of the tournament branch predictor (AlphaBranchPredictor) and shares it between two requesters: fetch lookups and execute-stage resolutions.
- Runs each lookup as a fixed-length PC hold, then samples the prediction.
- Keeps in-flight branches (PC plus predicted direction) in an in-order queue.
- Replays each resolved outcome to the predictor as a fixed-length update phase and flags mispredictions.

Parameters:
- PC_W, 10, predictor PC width.
- DEPTH, 4, in-flight branch queue entries; power of 2, ≥2.
- LOOKUP_CYC, 4, cycles PC is held before prediction is sampled; ≥1.
- UPDATE_CYC, 4, cycles PC+outcome are held for a predictor update; ≥1.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- lk_valid  in  1  fetch lookup request.
- lk_pc  in  PC_W  lookup PC.
- lk_ready  out  1  lookup accepted when lk_valid&&lk_ready.
- pred_valid  out  1  one-cycle pulse: prediction result.
- pred_taken  out  1  predicted direction, valid with pred_valid.
- rs_valid  in  1  execute resolution, in program order.
- rs_taken  in  1  actual outcome.
- rs_ready  out  1  resolution accepted when rs_valid&&rs_ready.
- mispredict  out  1  one-cycle pulse when an accepted resolution differs from the stored prediction.
- bp_pc  out  PC_W  to predictor PC.
- bp_taken  out  1  to predictor BranchTaken; 0 outside UPDATE.
- bp_predicted  in  1  from predictor PredictedBranch.
- q_count  out  $clog2(DEPTH)+1  in-flight entries.

Behaviour:
- Reset (reset==0, async): state=IDLE, queue empty, counters 0. All outputs 0 (lk_ready, rs_ready, pred_valid, pred_taken, mispredict, bp_pc, bp_taken, q_count).
- FSM states: IDLE, LOOKUP, UPDATE.
- IDLE arbitration, evaluated each cycle; resolution has strict priority (frees entries):
  - If rs_valid && queue non-empty: rs_ready=1 (combinational, IDLE only). Pop head. Latch head PC and rs_taken. mispredict pulses the same cycle if rs_taken != head.pred. Go to UPDATE.
  - Else if lk_valid && queue not full: lk_ready=1. Latch lk_pc. Go to LOOKUP.
  - rs_valid with empty queue is ignored (rs_ready=0). Flag it under the optional feature.
- LOOKUP:
  - bp_pc = latched PC for exactly LOOKUP_CYC cycles; bp_taken=0.
  - On the last cycle, sample bp_predicted and push {pc, pred} to the queue tail.
  - Next cycle: pred_valid=1, pred_taken=sampled value. Return to IDLE.
  - Request-to-pred_valid latency = LOOKUP_CYC+1 cycles after acceptance.
- UPDATE:
  - bp_pc = latched PC and bp_taken = latched outcome for exactly UPDATE_CYC cycles.
  - Then return to IDLE; bp_taken returns to 0.
- Phase counter: $clog2(max(LOOKUP_CYC, UPDATE_CYC))+1 bits. Cleared on entry to each phase.
- Queue: circular buffer with wrapping read/write pointers plus a count.
  - Full at count==DEPTH; empty at count==0.
  - Push and pop never occur in the same cycle, by construction.
- Back-to-back: no bubble is required beyond the IDLE arbitration cycle. Each transaction costs phase length +1 cycles.
- A lookup and a resolution presented together: resolution wins. Lookup stays pending; requester holds lk_valid/lk_pc stable.
- Reset mid-phase: phase aborted, queue flushed, no pred_valid or mispredict emitted.

Optional Feature:
- Macro BP_SEQ_STATS_EN.
- When defined, adds outputs:
  - stat_lookups (16b), saturating count of accepted lookups.
  - stat_mispredicts (16b), saturating count of mispredict pulses.
  - stat_orphan (1b), sticky; set when rs_valid is seen in IDLE with an empty queue.
- All three cleared by reset.
- When undefined, the ports and logic are absent; core behaviour is identical.

Decomposition:
- Package bp_seq_pkg:
  - typedef enum state_t {IDLE, LOOKUP, UPDATE}.
  - typedef struct packed bp_entry_t {pc, pred}.
  - Default PC_W constant.
- One natural sub-module, bp_inflight_fifo: the DEPTH-entry queue of bp_entry_t with push/pop/full/empty/count.

Test Plan:
- Reset held low mid-LOOKUP → all outputs 0 immediately, q_count=0; after release, state IDLE.
- Lookup pc=0, predictor stub returns 1 → bp_pc=0 for 4 cycles, pred_valid/pred_taken=1 on cycle 5, q_count=1.
- Then resolve rs_taken=0 → mispredict pulse, bp_pc=0 and bp_taken=0 for 4 cycles, q_count=0. Repeat with rs_taken=1 → no mispredict, bp_taken=1 for 4 cycles.
- Four lookups pcs 1..4 with lk_valid held → lk_ready=0 after fourth (full). Resolve once → head pc=1 updated first. Fifth lookup then accepted; pointers wrap.
- lk_valid and rs_valid asserted in the same IDLE cycle with queue non-empty → UPDATE first, then LOOKUP; no request lost.
- rs_valid with empty queue → rs_ready=0, no bp_taken activity; with BP_SEQ_STATS_EN, stat_orphan=1.
